hazard_scoreboard: RTL and testbench

//  Parametrised RAW hazard unit for the in-order pipeline, sitting beside the ID stage.

---
 rtl/hazard_scoreboard.sv | 85 ++++++++
 tb/tb_hazard_scoreboard.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW hazard unit for the in-order pipeline: one countdown counter per architectural
// register. ID is stalled while any source it reads still has a nonzero count.

module hazard_scoreboard_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  output logic          busy
);
  logic [CW-1:0] cnt;

  // A new writer's load wins over the decrement in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)             cnt <= '0;
    else if (ld)         cnt <= ld_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
endmodule

module hazard_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int WB_LAT   = 3,
  parameter int LOAD_LAT = 1,
  parameter int FWD_EN   = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic             id_rs1_used,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_count
);
  localparam int CW = $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] WB_V   = CW'(WB_LAT);
  localparam logic [CW-1:0] LOAD_V = CW'(LOAD_LAT);

  logic [NUM_REGS-1:0] busy;
  logic [CW-1:0]       ld_val;
  logic                hazard;
  logic                issue;

  // Hazard uses pre-issue state, so an instruction never stalls on its own rd.
  assign hazard = (id_rs1_used & busy[id_rs1]) | (id_rs2_used & busy[id_rs2]);
  assign stall  = id_valid & hazard & ~flush;
  assign issue  = id_valid & ~stall & ~flush;

  assign pc_write_en   = ~stall;
  assign ifid_write_en = ~stall;
  assign idex_bubble   = stall | flush;

  // With forwarding only loads leave a pending window; ALU writers clear the entry.
  assign ld_val = (FWD_EN != 0) ? (id_is_load ? LOAD_V : '0) : WB_V;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    hazard_scoreboard_cnt #(.CW(CW)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .ld     (issue & id_rd_we & (id_rd == REG_W'(r))),
      .ld_val (ld_val),
      .busy   (busy[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)                           stall_count <= '0;
    else if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Drives a no-forwarding and a forwarding scoreboard from the same ID stream and
// compares both against a per-register pending-cycles model every cycle.

module tb_hazard_scoreboard;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       valid = 0, rs1u = 0, rs2u = 0, rdwe = 0, isld = 0, flush = 0;
  logic [2:0] rs1 = 0, rs2 = 0, rd = 0;

  logic s0, pw0, iw0, b0, s1, pw1, iw1, b1;
  logic [3:0]  c0;
  logic [15:0] c1;

  hazard_scoreboard #(.WB_LAT(3), .FWD_EN(0), .CNT_W(4)) d0 (
    .clk(clk), .rst(rst), .id_valid(valid), .id_rs1(rs1), .id_rs1_used(rs1u),
    .id_rs2(rs2), .id_rs2_used(rs2u), .id_rd(rd), .id_rd_we(rdwe), .id_is_load(isld),
    .flush(flush), .stall(s0), .pc_write_en(pw0), .ifid_write_en(iw0),
    .idex_bubble(b0), .stall_count(c0));

  hazard_scoreboard #(.WB_LAT(3), .LOAD_LAT(1), .FWD_EN(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .id_valid(valid), .id_rs1(rs1), .id_rs1_used(rs1u),
    .id_rs2(rs2), .id_rs2_used(rs2u), .id_rd(rd), .id_rd_we(rdwe), .id_is_load(isld),
    .flush(flush), .stall(s1), .pc_write_en(pw1), .ifid_write_en(iw1),
    .idex_bubble(b1), .stall_count(c1));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: remaining pending cycles per register, per instance (0 = no fwd, 1 = fwd).
  int pend[2][8];
  int sc[2];
  int scmax[2] = '{15, 65535};
  logic last_s0, last_s1;

  function automatic bit mstall(input int f);
    bit hz;
    hz = (rs1u && pend[f][rs1] > 0) || (rs2u && pend[f][rs2] > 0);
    return valid && hz && !flush;
  endfunction

  task automatic mupd();
    for (int f = 0; f < 2; f++) begin
      bit st, iss;
      st  = mstall(f);
      iss = valid && !st && !flush;
      if (rst) begin
        for (int r = 0; r < 8; r++) pend[f][r] = 0;
        sc[f] = 0;
      end else begin
        for (int r = 0; r < 8; r++) if (pend[f][r] > 0) pend[f][r]--;
        if (iss && rdwe) pend[f][rd] = (f == 1) ? (isld ? 1 : 0) : 3;
        if (st && sc[f] < scmax[f]) sc[f]++;
      end
    end
  endtask

  // One cycle: inputs are already driven; check combinational outputs, then clock.
  task automatic step();
    bit e0, e1;
    #1;
    e0 = mstall(0);
    e1 = mstall(1);
    chk("stall0", s0, e0);   chk("stall1", s1, e1);
    chk("pcwe0", pw0, !e0);  chk("pcwe1", pw1, !e1);
    chk("ifid0", iw0, !e0);  chk("ifid1", iw1, !e1);
    chk("bub0", b0, e0 || flush); chk("bub1", b1, e1 || flush);
    chk("cnt0", c0, sc[0]);  chk("cnt1", c1, sc[1]);
    last_s0 = s0; last_s1 = s1;
    @(posedge clk);
    mupd();
    #1;
  endtask

  task automatic drv(input logic v, input int a, input logic au, input int b, input logic bu,
                     input int d, input logic we, input logic ld, input logic fl);
    valid = v; rs1 = 3'(a); rs1u = au; rs2 = 3'(b); rs2u = bu;
    rd = 3'(d); rdwe = we; isld = ld; flush = fl;
    step();
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); rst = 1'b0;
  endtask

  initial begin
    int n;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 8; r++) pend[f][r] = 0;
      sc[f] = 0;
    end
    @(posedge clk); #1;
    do_reset();
    #1;
    chk("rst_stall", s0, 0); chk("rst_pcwe", pw0, 1); chk("rst_ifid", iw0, 1);
    chk("rst_bub", b0, 0);   chk("rst_cnt", c0, 0);   chk("rst_cnt1", c1, 0);

    // ALU write r3 then reader: 3 stalls without forwarding, none with.
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      drv(1, 3, 1, 0, 0, 6, 1, 0, 0);
      if (!last_s0) break;
      n++;
    end
    chk("t1_stalls", n, 3); chk("t1_cnt0", c0, 3); chk("t1_cnt1", c1, 0);

    // Load r2 then reader on rs2: forwarding instance stalls exactly once.
    do_reset();
    drv(1, 0, 0, 0, 0, 2, 1, 1, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, 0, 2, 1, 7, 1, 0, 0);
      if (!last_s1 && !last_s0) break;
      if (last_s1) n++;
    end
    chk("t2_ld_stalls", n, 1); chk("t2_cnt1", c1, 1);

    // Flush of a stalled reader: no stall, bubble, pending entry still decays.
    do_reset();
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0);
    idle();
    drv(1, 5, 1, 0, 0, 1, 1, 0, 1);
    chk("t3_stall", last_s0, 0); chk("t3_bub", b0 | flush, 1);
    drv(1, 5, 1, 0, 0, 1, 1, 0, 0);
    chk("t3_post", last_s0, 1);
    drv(1, 5, 1, 0, 0, 1, 1, 0, 0);
    chk("t3_issue", last_s0, 0);

    // Unused source and invalid ID never stall.
    do_reset();
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    drv(1, 3, 0, 1, 1, 0, 0, 0, 0);
    chk("t4_unused", last_s0, 0);
    drv(0, 3, 1, 3, 1, 0, 0, 0, 0);
    chk("t4_invalid", last_s0, 0);

    // Reset discards a pending entry.
    do_reset();
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0);
    drv(1, 0, 0, 4, 1, 0, 0, 0, 0);
    do_reset();
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0);
    chk("t5_stall", last_s0, 0); chk("t5_cnt", c0, 0);

    // Saturation at 15 for the 4-bit counter.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 6; i++) begin
        drv(1, 1, 1, 0, 0, 2, 1, 0, 0);
        if (!last_s0) break;
      end
    end
    chk("t6_sat", c0, 15);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 9) == 0);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
